// File: rtl/ndata_compactor.sv
// Packs a sparse ndata stream (any per-element keep pattern) into a dense one:
// every output beat is full except the last beat of a packet, and its keep is contiguous from lane 0.
module ndata_compactor #(
   parameter int NUM_ELEMENTS = 8,
   parameter int DATA_WIDTH   = 64
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   in_data,
   input  logic [NUM_ELEMENTS-1:0]              in_keep,
   input  logic                                 in_last,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   out_data,
   output logic [NUM_ELEMENTS-1:0]              out_keep,
   output logic                                 out_last,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam int N  = NUM_ELEMENTS;
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(N);

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   logic [0:0]    state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [W-1:0]  carry      [N-1];
   logic [W-1:0]  carry_next [N-1];
   logic [W-1:0]  compacted  [N];
   logic [W-1:0]  merged     [2*N-1];

   logic              slot_free, accept, flush_go, load;
   logic [N-1:0]      keep_next;
   logic              last_next;
   logic [N*W-1:0]    data_next;
   int                c_i, k_i, t_i, x_i, p;

   always_comb begin
      slot_free = !out_valid || out_ready;
      in_ready  = slot_free && (state == RUN);
      accept    = in_valid && in_ready;
      flush_go  = (state == FLUSH) && slot_free;

      c_i = int'(cnt);
      k_i = 0;
      for (int i = 0; i < N; i++) begin
         if (in_keep[i]) k_i++;
      end
      t_i = c_i + k_i;

      // Kept input element i lands on lane p, its prefix count of kept elements below it.
      for (int m = 0; m < N; m++) compacted[m] = '0;
      p = 0;
      for (int i = 0; i < N; i++) begin
         for (int m = 0; m < N; m++) begin
            if (in_keep[i] && (p == m)) compacted[m] = in_data[i*W +: W];
         end
         if (in_keep[i]) p++;
      end

      // Candidate stream: carried elements first, then the compacted input.
      for (int j = 0; j < 2*N-1; j++) begin
         merged[j] = '0;
         for (int m = 0; m < N; m++) begin
            if (j == c_i + m) merged[j] = compacted[m];
         end
      end
      for (int m = 0; m < N-1; m++) begin
         if (m < c_i) merged[m] = carry[m];
      end

      for (int j = 0; j < N-1; j++) begin
         carry_next[j] = (t_i >= N) ? merged[j+N] : merged[j];
      end

      load       = 1'b0;
      x_i        = 0;
      last_next  = 1'b0;
      cnt_next   = cnt;
      state_next = state;
      if (flush_go) begin
         load       = 1'b1;
         x_i        = c_i;
         last_next  = 1'b1;
         cnt_next   = '0;
         state_next = RUN;
      end else if (accept) begin
         if (t_i >= N) begin
            load      = 1'b1;
            x_i       = N;
            last_next = in_last && (t_i == N);
            cnt_next  = CW'(t_i - N);
            if (in_last && (t_i > N)) state_next = FLUSH;
         end else if (in_last) begin
            load      = 1'b1;
            x_i       = t_i;
            last_next = 1'b1;
            cnt_next  = '0;
         end else begin
            cnt_next  = CW'(t_i);
         end
      end

      for (int j = 0; j < N; j++) keep_next[j] = (j < x_i);

      for (int j = 0; j < N-1; j++) begin
         data_next[j*W +: W] = flush_go ? carry[j] : merged[j];
      end
      data_next[(N-1)*W +: W] = flush_go ? '0 : merged[N-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         cnt       <= '0;
         state     <= RUN;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_keep  <= keep_next;
            out_last  <= last_next;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         cnt   <= cnt_next;
         state <= state_next;
      end
   end

   // NOTE: payload registers carry no reset; validity is tracked by out_valid and cnt alone.
   always_ff @(posedge clk) begin
      if (load) out_data <= data_next;
      if (accept) begin
         for (int j = 0; j < N-1; j++) carry[j] <= carry_next[j];
      end
   end

endmodule

// File: tb/tb_ndata_compactor.sv
// Directed bench for ndata_compactor at N=4: dense, merge, overflow flush,
// backpressure, empty packets and mid-packet reset.
module tb_ndata_compactor;

   localparam int N = 4;
   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_keep;
   logic             in_last;
   logic             in_valid;
   logic             in_ready;
   logic [N*W-1:0]   out_data;
   logic [N-1:0]     out_keep;
   logic             out_last;
   logic             out_valid;
   logic             out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   ndata_compactor #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [N*W-1:0] beat(input int e0, input int e1, input int e2, input int e3);
      return {W'(e3), W'(e2), W'(e1), W'(e0)};
   endfunction

   function automatic logic [N*W-1:0] masked(input logic [N*W-1:0] d, input logic [N-1:0] k);
      logic [N*W-1:0] r;
      r = '0;
      for (int e = 0; e < N; e++) begin
         if (k[e]) r[e*W +: W] = d[e*W +: W];
      end
      return r;
   endfunction

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one input beat, wait (bounded) for acceptance, then drop in_valid.
   task automatic send(input string tag, input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
      int waited;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) check({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_beat(input string tag, input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_keep"}, 64'(out_keep), 64'(k));
      check({tag, "_last"}, 64'(out_last), 64'(l));
      check({tag, "_data"}, 64'(masked(out_data, k)), 64'(masked(d, k)));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_keep   = '0;
      in_last   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_keep", 64'(out_keep), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // 1. Dense beats pass straight through, one cycle after acceptance.
      out_ready = 1'b1;
      send("dense1", beat(1, 2, 3, 4), 4'b1111, 1'b0);
      check_beat("dense1", beat(1, 2, 3, 4), 4'b1111, 1'b0);
      send("dense2", beat(5, 6, 7, 8), 4'b1111, 1'b0);
      check_beat("dense2", beat(5, 6, 7, 8), 4'b1111, 1'b0);
      send("dense3", beat(9, 10, 11, 12), 4'b1111, 1'b1);
      check_beat("dense3", beat(9, 10, 11, 12), 4'b1111, 1'b1);
      step();
      check_idle("dense_drain");

      // 2. Two half-empty beats merge into one full beat.
      send("merge1", beat('hA, 'hEE, 'hB, 'hEE), 4'b0101, 1'b0);
      check_idle("merge1_nobeat");
      send("merge2", beat('hEE, 'hC, 'hEE, 'hD), 4'b1010, 1'b1);
      check_beat("merge2", beat('hA, 'hB, 'hC, 'hD), 4'b1111, 1'b1);
      step();
      check_idle("merge_drain");

      // 3. Overflow on the last beat forces a flush beat.
      send("ovf1", beat(1, 2, 3, 'hEE), 4'b0111, 1'b0);
      check_idle("ovf1_nobeat");
      send("ovf2", beat(4, 5, 6, 7), 4'b1111, 1'b1);
      check_beat("ovf_full", beat(1, 2, 3, 4), 4'b1111, 1'b0);
      check("ovf_flush_in_ready", 64'(in_ready), 64'd0);
      step();
      check_beat("ovf_flush", beat(5, 6, 7, 0), 4'b0111, 1'b1);
      check("ovf_after_in_ready", 64'(in_ready), 64'd1);
      step();
      check_idle("ovf_drain");

      // 4. Backpressure holds the slot and blocks input.
      out_ready = 1'b0;
      send("bp1", beat(31, 32, 33, 34), 4'b1111, 1'b0);
      check_beat("bp_first", beat(31, 32, 33, 34), 4'b1111, 1'b0);
      in_data  = beat(35, 36, 37, 38);
      in_keep  = 4'b1111;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check_beat("bp_hold", beat(31, 32, 33, 34), 4'b1111, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check_beat("bp_second", beat(35, 36, 37, 38), 4'b1111, 1'b1);
      step();
      check_idle("bp_drain");

      // 5. Empty packets.
      send("empty_last", beat(0, 0, 0, 0), 4'b0000, 1'b1);
      check_beat("empty_last", beat(0, 0, 0, 0), 4'b0000, 1'b1);
      send("empty_mid", beat(0, 0, 0, 0), 4'b0000, 1'b0);
      check_idle("empty_mid");
      send("empty_next", beat(41, 42, 43, 44), 4'b1111, 1'b1);
      check_beat("empty_next", beat(41, 42, 43, 44), 4'b1111, 1'b1);
      step();
      check_idle("empty_drain");

      // 6. Reset with three carried elements and a stalled output beat.
      out_ready = 1'b0;
      send("rstp1", beat(11, 12, 13, 'hEE), 4'b0111, 1'b0);
      send("rstp2", beat(14, 15, 16, 17), 4'b1111, 1'b0);
      check_beat("rstp_pending", beat(11, 12, 13, 14), 4'b1111, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_out_keep", 64'(out_keep), 64'd0);
      check("rst2_out_last", 64'(out_last), 64'd0);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send("fresh", beat(21, 22, 23, 24), 4'b1111, 1'b1);
      check_beat("fresh", beat(21, 22, 23, 24), 4'b1111, 1'b1);
      step();
      check_idle("fresh_drain");
      step();
      check_idle("fresh_no_flush");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
